task_sink_core: RTL and testbench
=================================

Name: task_sink_core

Overview:
- Parametrised successor to the per-app task terminator: the sink stage where finished tasks retire inside a Swarm core slot.
- Accepts one task per ap_start and optionally holds it for a fixed drain latency.
- Optionally spawns one child task on the task_out stream when the task type matches a programmable spawn type.
- Keeps per-ttype retirement counters that software reads through ap_state; the undo log and L1 AXI channels stay idle.

Parameters:
TS_WIDTH, 32, timestamp field width (bits [TS_WIDTH-1:0] of task)
LOCALE_WIDTH, 32, locale field width (next field up)
TTYPE_WIDTH, 4, task type field width (next field up)
ARGS_WIDTH, 64, args field width (top field)
NUM_TTYPES, 8, number of per-type counters, ≤ 2^TTYPE_WIDTH
CNT_WIDTH, 32, counter width, ≤ 32
DRAIN_CYCLES, 0, extra cycles spent in DRAIN before completion
TS_INC, 1, timestamp increment applied to a spawned child
CHILD_TTYPE, 1, ttype written into a spawned child

Ports:
ap_clk  in  1  clock
ap_rst  in  1  asynchronous, active-high reset
ap_start  in  1  task_in valid; sampled only in IDLE
ap_done  out  1  one-cycle completion pulse
ap_idle  out  1  high in IDLE
ap_ready  out  1  high in IDLE
task_in  in  TQ_WIDTH  {args,ttype,locale,ts}, where TQ_WIDTH = sum of the four field widths
spawn_en  in  1  quasi-static enable for child spawning
spawn_ttype  in  TTYPE_WIDTH  ttype that triggers a spawn
task_out_V_TDATA  out  TQ_WIDTH  child task
task_out_V_TVALID  out  1  child valid
task_out_V_TREADY  in  1  child accepted
undo_log_entry  out  UNDO_LOG_ADDR_WIDTH+UNDO_LOG_DATA_WIDTH  tied 0
undo_log_entry_ap_vld  out  1  tied 0
undo_log_entry_ap_rdy  in  1  ignored
m_axi_l1_V_*  mixed  standard core L1 bundle  all outputs tied 0 (AWVALID, WVALID, ARVALID, RREADY, BREADY = 0)
stat_sel  in  8  counter select
stat_clr  in  1  synchronous clear of all counters
ap_state  out  32  selected counter, zero-extended

Behaviour:
- Reset (async assert, sync deassert inside the block) forces:
  - state IDLE, all counters 0
  - ap_done 0, ap_idle 1, ap_ready 1
  - TVALID 0, TDATA 0
- Reset during DRAIN or EMIT aborts the task immediately; TVALID drops combinationally with reset and nothing is counted.
- FSM states: IDLE, DRAIN, EMIT, DONE.
  - IDLE: if ap_start, latch task_in into the held task. Next state is DRAIN if DRAIN_CYCLES>0; otherwise EMIT if spawn; otherwise DONE.
  - spawn = spawn_en && (held ttype == spawn_ttype), evaluated when leaving IDLE.
  - DRAIN: down-counter loaded with DRAIN_CYCLES-1 on entry. At 0 the next state is EMIT if spawn, else DONE. Exactly DRAIN_CYCLES cycles are spent in DRAIN.
  - EMIT: TVALID=1 with TDATA stable until TVALID&&TREADY, then DONE. No timeout.
  - DONE: ap_done=1 for one cycle, counters update, then IDLE.
- ap_start outside IDLE is ignored; task_in is don't-care outside the IDLE sampling cycle.
- Latency from ap_start to ap_done: 1 + DRAIN_CYCLES + (spawn ? stall+1 : 0) cycles. Back-to-back throughput is one task per 2 + DRAIN_CYCLES cycles with no spawn.
- Child fields:
  - ts = (parent ts + TS_INC) mod 2^TS_WIDTH; wrap is silent
  - locale = parent locale
  - ttype = CHILD_TTYPE
  - args = parent args
- Counters, updated in DONE:
  - cnt[ttype] increments if ttype < NUM_TTYPES; other ttypes increment only total.
  - total increments always.
  - spawn_cnt increments if a child was emitted.
  - All counters saturate at 2^CNT_WIDTH-1.
  - stat_clr in the same cycle as DONE: clear first, then the increment applies, so the counter reads 1.
- ap_state (combinational from registers):
  - stat_sel < NUM_TTYPES gives cnt[stat_sel]
  - stat_sel == NUM_TTYPES gives total
  - stat_sel == NUM_TTYPES+1 gives spawn_cnt
  - any other stat_sel gives 0

Optional Feature:
- Macro: TASK_SINK_TS_ORDER_CHECK_EN.
- With it defined:
  - The block keeps the last retired ts.
  - A sticky order_err bit sets when a retiring ts is strictly below the previous one (unsigned).
  - order_err is cleared by ap_rst or stat_clr and reported on ap_state[31]; counter values show on bits [30:0], truncated.
- Without it: no extra registers, and ap_state is the plain zero-extended counter.

Test Plan:
- Reset then idle: ap_idle=1, ap_state=0 for stat_sel 0..NUM_TTYPES+1, TVALID=0.
- Single task, ttype 2, DRAIN_CYCLES=0, spawn_en=0: ap_start at cycle 0 gives ap_done at cycle 1 and ap_idle at cycle 2; cnt[2]=1, total=1.
- DRAIN_CYCLES=3, spawn_en=1, spawn_ttype=2, task ts=0xFFFFFFFF, TREADY held low 5 cycles: TVALID from cycle 4 stays stable. Child ts=0x00000000 with ttype 1. ap_done comes 1 cycle after the handshake; spawn_cnt=1.
- Saturation with CNT_WIDTH=4: 20 ttype-0 tasks leave cnt[0]=15, total=15. stat_clr coincident with a DONE gives total=1.
- ttype 12 with NUM_TTYPES=8: total increments, no cnt changes, stat_sel=12 reads 0.
- TASK_SINK_TS_ORDER_CHECK_EN: ts 10 then 5 sets ap_state[31]=1, which stays 1 until stat_clr. ap_rst asserted mid-EMIT drops TVALID immediately, counters go to 0, and order_err clears.

Source files
------------

// File: rtl/task_sink_core.sv
// -----------------------------------------------------------------------------
// task_sink_core
//
// Sink stage where finished tasks retire inside a Swarm core slot. One task is
// accepted per ap_start while IDLE, optionally held for DRAIN_CYCLES cycles,
// optionally used to spawn a single child task on the task_out stream, and then
// retired with a one-cycle ap_done pulse. Per-ttype, total and spawn retirement
// counters are readable through ap_state. The undo log port and the L1 AXI
// master bundle are present for slot compatibility but stay idle.
//
// Optional feature (compile-time macro TASK_SINK_TS_ORDER_CHECK_EN):
//   keeps the last retired timestamp and a sticky order_err flag that sets when
//   a retiring ts is strictly below the previous one. order_err appears on
//   ap_state[31]; the selected counter is then truncated to ap_state[30:0].
//
// Ports:
//   ap_clk, ap_rst          clock, asynchronous active-high reset
//   ap_start                task_in valid, sampled only in IDLE
//   ap_done                 one-cycle completion pulse
//   ap_idle, ap_ready       high in IDLE
//   task_in                 {args, ttype, locale, ts}
//   spawn_en, spawn_ttype   child spawn enable and trigger ttype
//   task_out_V_*            child task stream (TDATA/TVALID/TREADY)
//   undo_log_entry*         undo log port, outputs tied 0
//   m_axi_l1_V_*            L1 AXI master bundle, outputs tied 0
//   stat_sel, stat_clr      counter select, synchronous clear of all counters
//   ap_state                selected counter (plus order_err with the macro)
//   state_dbg               current FSM state, for observation
// -----------------------------------------------------------------------------
module task_sink_core #(
    parameter int TS_WIDTH            = 32,
    parameter int LOCALE_WIDTH        = 32,
    parameter int TTYPE_WIDTH         = 4,
    parameter int ARGS_WIDTH          = 64,
    parameter int NUM_TTYPES          = 8,
    parameter int CNT_WIDTH           = 32,
    parameter int DRAIN_CYCLES        = 0,
    parameter int TS_INC              = 1,
    parameter int CHILD_TTYPE         = 1,
    parameter int UNDO_LOG_ADDR_WIDTH = 32,
    parameter int UNDO_LOG_DATA_WIDTH = 32,
    parameter int L1_ADDR_WIDTH       = 64,
    parameter int L1_DATA_WIDTH       = 64,
    localparam int TQ_WIDTH = ARGS_WIDTH + TTYPE_WIDTH + LOCALE_WIDTH + TS_WIDTH
) (
    input  logic                                          ap_clk,
    input  logic                                          ap_rst,
    input  logic                                          ap_start,
    output logic                                          ap_done,
    output logic                                          ap_idle,
    output logic                                          ap_ready,
    input  logic [TQ_WIDTH-1:0]                           task_in,
    input  logic                                          spawn_en,
    input  logic [TTYPE_WIDTH-1:0]                        spawn_ttype,
    output logic [TQ_WIDTH-1:0]                           task_out_V_TDATA,
    output logic                                          task_out_V_TVALID,
    input  logic                                          task_out_V_TREADY,
    output logic [UNDO_LOG_ADDR_WIDTH+UNDO_LOG_DATA_WIDTH-1:0] undo_log_entry,
    output logic                                          undo_log_entry_ap_vld,
    input  logic                                          undo_log_entry_ap_rdy,
    output logic [L1_ADDR_WIDTH-1:0]                      m_axi_l1_V_AWADDR,
    output logic [7:0]                                    m_axi_l1_V_AWLEN,
    output logic [2:0]                                    m_axi_l1_V_AWSIZE,
    output logic [1:0]                                    m_axi_l1_V_AWBURST,
    output logic                                          m_axi_l1_V_AWVALID,
    input  logic                                          m_axi_l1_V_AWREADY,
    output logic [L1_DATA_WIDTH-1:0]                      m_axi_l1_V_WDATA,
    output logic [L1_DATA_WIDTH/8-1:0]                    m_axi_l1_V_WSTRB,
    output logic                                          m_axi_l1_V_WLAST,
    output logic                                          m_axi_l1_V_WVALID,
    input  logic                                          m_axi_l1_V_WREADY,
    input  logic [1:0]                                    m_axi_l1_V_BRESP,
    input  logic                                          m_axi_l1_V_BVALID,
    output logic                                          m_axi_l1_V_BREADY,
    output logic [L1_ADDR_WIDTH-1:0]                      m_axi_l1_V_ARADDR,
    output logic [7:0]                                    m_axi_l1_V_ARLEN,
    output logic [2:0]                                    m_axi_l1_V_ARSIZE,
    output logic [1:0]                                    m_axi_l1_V_ARBURST,
    output logic                                          m_axi_l1_V_ARVALID,
    input  logic                                          m_axi_l1_V_ARREADY,
    input  logic [L1_DATA_WIDTH-1:0]                      m_axi_l1_V_RDATA,
    input  logic [1:0]                                    m_axi_l1_V_RRESP,
    input  logic                                          m_axi_l1_V_RLAST,
    input  logic                                          m_axi_l1_V_RVALID,
    output logic                                          m_axi_l1_V_RREADY,
    input  logic [7:0]                                    stat_sel,
    input  logic                                          stat_clr,
    output logic [31:0]                                   ap_state,
    output logic [1:0]                                    state_dbg
);

    // Field offsets inside a task word: {args, ttype, locale, ts}.
    localparam int LOC_LSB  = TS_WIDTH;
    localparam int TT_LSB   = TS_WIDTH + LOCALE_WIDTH;
    localparam int ARGS_LSB = TS_WIDTH + LOCALE_WIDTH + TTYPE_WIDTH;

    localparam int DRAIN_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD =
        DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Reset: asserts asynchronously, released two clocks after ap_rst falls so
    // every flop leaves reset on the same edge.
    // ------------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_i;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) rst_sync_q <= 2'b11;
        else        rst_sync_q <= {rst_sync_q[0], 1'b0};
    end

    assign rst_i = rst_sync_q[1];

    // ------------------------------------------------------------------------
    // Held task and control state
    // ------------------------------------------------------------------------
    state_t                  state_q, state_d;
    logic [TQ_WIDTH-1:0]     task_q;
    logic                    spawn_q;
    logic [DRAIN_W-1:0]      drain_q;

    logic [TS_WIDTH-1:0]     held_ts;
    logic [LOCALE_WIDTH-1:0] held_locale;
    logic [TTYPE_WIDTH-1:0]  held_ttype;
    logic [ARGS_WIDTH-1:0]   held_args;
    logic                    spawn_now;
    logic                    retire;

    assign held_ts     = task_q[TS_WIDTH-1:0];
    assign held_locale = task_q[LOC_LSB +: LOCALE_WIDTH];
    assign held_ttype  = task_q[TT_LSB +: TTYPE_WIDTH];
    assign held_args   = task_q[ARGS_LSB +: ARGS_WIDTH];

    // Spawn decision is taken from the incoming task while leaving IDLE and
    // then frozen, so later changes of spawn_en/spawn_ttype do not matter.
    assign spawn_now = spawn_en && (task_in[TT_LSB +: TTYPE_WIDTH] == spawn_ttype);
    assign retire    = (state_q == S_DONE);

    always_ff @(posedge ap_clk or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    if (DRAIN_CYCLES > 0) state_d = S_DRAIN;
                    else if (spawn_now)   state_d = S_EMIT;
                    else                  state_d = S_DONE;
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) state_d = spawn_q ? S_EMIT : S_DONE;
            end
            S_EMIT: begin
                if (task_out_V_TREADY) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge rst_i) begin
        if (rst_i) begin
            task_q  <= '0;
            spawn_q <= 1'b0;
            drain_q <= '0;
        end else begin
            if (state_q == S_IDLE && ap_start) begin
                task_q  <= task_in;
                spawn_q <= spawn_now;
            end
            // Reloaded every IDLE cycle so it holds DRAIN_CYCLES-1 on DRAIN entry.
            if (state_q == S_IDLE)
                drain_q <= DRAIN_LOAD;
            else if (state_q == S_DRAIN && drain_q != '0)
                drain_q <= drain_q - DRAIN_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Child stream. valid/ready: TVALID is raised in EMIT with TDATA stable
    // and is never withdrawn until a cycle with TVALID && TREADY, which is the
    // only transfer point; TREADY may change freely and has no timeout.
    // ------------------------------------------------------------------------
    logic [TQ_WIDTH-1:0] child;

    assign child = {held_args,
                    TTYPE_WIDTH'(CHILD_TTYPE),
                    held_locale,
                    held_ts + TS_WIDTH'(TS_INC)};

    assign task_out_V_TVALID = (state_q == S_EMIT);
    assign task_out_V_TDATA  = (state_q == S_EMIT) ? child : '0;

    assign ap_done   = (state_q == S_DONE);
    assign ap_idle   = (state_q == S_IDLE);
    assign ap_ready  = (state_q == S_IDLE);
    assign state_dbg = state_q;

    // ------------------------------------------------------------------------
    // Retirement counters: clear is applied before the increment, and all
    // counters saturate at their maximum.
    // ------------------------------------------------------------------------
    function automatic logic [CNT_WIDTH-1:0] cnt_next(
        input logic [CNT_WIDTH-1:0] cur,
        input logic                 clr,
        input logic                 inc
    );
        logic [CNT_WIDTH-1:0] base;
        base = clr ? '0 : cur;
        if (inc && base != '1) base = base + CNT_WIDTH'(1);
        return base;
    endfunction

    logic [CNT_WIDTH-1:0] cnt_q [NUM_TTYPES];
    logic [CNT_WIDTH-1:0] total_q;
    logic [CNT_WIDTH-1:0] spawn_cnt_q;

    always_ff @(posedge ap_clk or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_TTYPES; i++) cnt_q[i] <= '0;
            total_q     <= '0;
            spawn_cnt_q <= '0;
        end else begin
            // ttypes at or above NUM_TTYPES match no index and only bump total.
            for (int i = 0; i < NUM_TTYPES; i++)
                cnt_q[i] <= cnt_next(cnt_q[i], stat_clr, retire && (int'(held_ttype) == i));
            total_q     <= cnt_next(total_q, stat_clr, retire);
            spawn_cnt_q <= cnt_next(spawn_cnt_q, stat_clr, retire && spawn_q);
        end
    end

    logic [CNT_WIDTH-1:0] sel_val;

    always_comb begin
        sel_val = '0;
        for (int i = 0; i < NUM_TTYPES; i++)
            if (int'(stat_sel) == i) sel_val = cnt_q[i];
        if (int'(stat_sel) == NUM_TTYPES)     sel_val = total_q;
        if (int'(stat_sel) == NUM_TTYPES + 1) sel_val = spawn_cnt_q;
    end

`ifdef TASK_SINK_TS_ORDER_CHECK_EN
    logic [TS_WIDTH-1:0] last_ts_q;
    logic                order_err_q;

    always_ff @(posedge ap_clk or posedge rst_i) begin
        if (rst_i) begin
            last_ts_q   <= '0;
            order_err_q <= 1'b0;
        end else begin
            if (retire) last_ts_q <= held_ts;
            // Same ordering as the counters: clear, then a violation may set it.
            order_err_q <= (stat_clr ? 1'b0 : order_err_q) ||
                           (retire && (held_ts < last_ts_q));
        end
    end

    assign ap_state = {order_err_q, 31'(sel_val)};
`else
    assign ap_state = 32'(sel_val);
`endif

    // ------------------------------------------------------------------------
    // Idle side ports
    // ------------------------------------------------------------------------
    assign undo_log_entry        = '0;
    assign undo_log_entry_ap_vld = 1'b0;

    assign m_axi_l1_V_AWADDR  = '0;
    assign m_axi_l1_V_AWLEN   = '0;
    assign m_axi_l1_V_AWSIZE  = '0;
    assign m_axi_l1_V_AWBURST = '0;
    assign m_axi_l1_V_AWVALID = 1'b0;
    assign m_axi_l1_V_WDATA   = '0;
    assign m_axi_l1_V_WSTRB   = '0;
    assign m_axi_l1_V_WLAST   = 1'b0;
    assign m_axi_l1_V_WVALID  = 1'b0;
    assign m_axi_l1_V_BREADY  = 1'b0;
    assign m_axi_l1_V_ARADDR  = '0;
    assign m_axi_l1_V_ARLEN   = '0;
    assign m_axi_l1_V_ARSIZE  = '0;
    assign m_axi_l1_V_ARBURST = '0;
    assign m_axi_l1_V_ARVALID = 1'b0;
    assign m_axi_l1_V_RREADY  = 1'b0;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, undo_log_entry_ap_rdy,
                             m_axi_l1_V_AWREADY, m_axi_l1_V_WREADY,
                             m_axi_l1_V_BRESP, m_axi_l1_V_BVALID,
                             m_axi_l1_V_ARREADY, m_axi_l1_V_RDATA,
                             m_axi_l1_V_RRESP, m_axi_l1_V_RLAST,
                             m_axi_l1_V_RVALID};

endmodule

// File: tb/tb_task_sink_core.sv
// -----------------------------------------------------------------------------
// tb_task_sink_core
//
// Two instances: u_a (DRAIN_CYCLES=0, CNT_WIDTH=4) and u_b (DRAIN_CYCLES=3,
// CNT_WIDTH=32). Cycle numbering: the cycle in which ap_start is high is
// cycle 0; cycle N is observed 1 ns after the N-th following rising edge.
// Expected children are pushed to exp_q when the parent is driven and popped
// at the TVALID && TREADY transfer.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_task_sink_core;
    localparam int TQ = 132;
`ifdef TASK_SINK_TS_ORDER_CHECK_EN
    localparam logic ORD_EN = 1'b1;
`else
    localparam logic ORD_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- shared and per-instance signals ----------------
    logic [TQ-1:0] task_in;
    logic          spawn_en;
    logic [3:0]    spawn_ttype;
    logic          stat_clr;

    logic start_a, done_a, idle_a, ready_a, tvalid_a, tready_a;
    logic start_b, done_b, idle_b, ready_b, tvalid_b, tready_b;
    logic [TQ-1:0] tdata_a, tdata_b;
    logic [7:0]    sel_a, sel_b;
    logic [31:0]   state_a, state_b;
    logic [1:0]    dbg_a, dbg_b;

    logic [63:0] a_undo, a_awaddr, a_wdata, a_araddr;
    logic [63:0] b_undo, b_awaddr, b_wdata, b_araddr;
    logic [7:0]  a_awlen, a_arlen, a_wstrb, b_awlen, b_arlen, b_wstrb;
    logic [2:0]  a_awsize, a_arsize, b_awsize, b_arsize;
    logic [1:0]  a_awburst, a_arburst, b_awburst, b_arburst;
    logic a_undo_vld, a_awvalid, a_wlast, a_wvalid, a_bready, a_arvalid, a_rready;
    logic b_undo_vld, b_awvalid, b_wlast, b_wvalid, b_bready, b_arvalid, b_rready;

    logic [TQ-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task_sink_core #(.DRAIN_CYCLES(0), .CNT_WIDTH(4)) u_a (
        .ap_clk(clk), .ap_rst(rst), .ap_start(start_a), .ap_done(done_a),
        .ap_idle(idle_a), .ap_ready(ready_a), .task_in(task_in),
        .spawn_en(spawn_en), .spawn_ttype(spawn_ttype),
        .task_out_V_TDATA(tdata_a), .task_out_V_TVALID(tvalid_a),
        .task_out_V_TREADY(tready_a),
        .undo_log_entry(a_undo), .undo_log_entry_ap_vld(a_undo_vld),
        .undo_log_entry_ap_rdy(1'b0),
        .m_axi_l1_V_AWADDR(a_awaddr), .m_axi_l1_V_AWLEN(a_awlen),
        .m_axi_l1_V_AWSIZE(a_awsize), .m_axi_l1_V_AWBURST(a_awburst),
        .m_axi_l1_V_AWVALID(a_awvalid), .m_axi_l1_V_AWREADY(1'b0),
        .m_axi_l1_V_WDATA(a_wdata), .m_axi_l1_V_WSTRB(a_wstrb),
        .m_axi_l1_V_WLAST(a_wlast), .m_axi_l1_V_WVALID(a_wvalid),
        .m_axi_l1_V_WREADY(1'b0), .m_axi_l1_V_BRESP(2'b00),
        .m_axi_l1_V_BVALID(1'b0), .m_axi_l1_V_BREADY(a_bready),
        .m_axi_l1_V_ARADDR(a_araddr), .m_axi_l1_V_ARLEN(a_arlen),
        .m_axi_l1_V_ARSIZE(a_arsize), .m_axi_l1_V_ARBURST(a_arburst),
        .m_axi_l1_V_ARVALID(a_arvalid), .m_axi_l1_V_ARREADY(1'b0),
        .m_axi_l1_V_RDATA(64'd0), .m_axi_l1_V_RRESP(2'b00),
        .m_axi_l1_V_RLAST(1'b0), .m_axi_l1_V_RVALID(1'b0),
        .m_axi_l1_V_RREADY(a_rready),
        .stat_sel(sel_a), .stat_clr(stat_clr), .ap_state(state_a),
        .state_dbg(dbg_a)
    );

    task_sink_core #(.DRAIN_CYCLES(3), .CNT_WIDTH(32)) u_b (
        .ap_clk(clk), .ap_rst(rst), .ap_start(start_b), .ap_done(done_b),
        .ap_idle(idle_b), .ap_ready(ready_b), .task_in(task_in),
        .spawn_en(spawn_en), .spawn_ttype(spawn_ttype),
        .task_out_V_TDATA(tdata_b), .task_out_V_TVALID(tvalid_b),
        .task_out_V_TREADY(tready_b),
        .undo_log_entry(b_undo), .undo_log_entry_ap_vld(b_undo_vld),
        .undo_log_entry_ap_rdy(1'b1),
        .m_axi_l1_V_AWADDR(b_awaddr), .m_axi_l1_V_AWLEN(b_awlen),
        .m_axi_l1_V_AWSIZE(b_awsize), .m_axi_l1_V_AWBURST(b_awburst),
        .m_axi_l1_V_AWVALID(b_awvalid), .m_axi_l1_V_AWREADY(1'b1),
        .m_axi_l1_V_WDATA(b_wdata), .m_axi_l1_V_WSTRB(b_wstrb),
        .m_axi_l1_V_WLAST(b_wlast), .m_axi_l1_V_WVALID(b_wvalid),
        .m_axi_l1_V_WREADY(1'b1), .m_axi_l1_V_BRESP(2'b00),
        .m_axi_l1_V_BVALID(1'b0), .m_axi_l1_V_BREADY(b_bready),
        .m_axi_l1_V_ARADDR(b_araddr), .m_axi_l1_V_ARLEN(b_arlen),
        .m_axi_l1_V_ARSIZE(b_arsize), .m_axi_l1_V_ARBURST(b_arburst),
        .m_axi_l1_V_ARVALID(b_arvalid), .m_axi_l1_V_ARREADY(1'b1),
        .m_axi_l1_V_RDATA(64'd0), .m_axi_l1_V_RRESP(2'b00),
        .m_axi_l1_V_RLAST(1'b0), .m_axi_l1_V_RVALID(1'b0),
        .m_axi_l1_V_RREADY(b_rready),
        .stat_sel(sel_b), .stat_clr(stat_clr), .ap_state(state_b),
        .state_dbg(dbg_b)
    );

    // ---------------- driver helpers ----------------
    function automatic logic [TQ-1:0] mk(input logic [63:0] args, input logic [3:0] tt,
                                         input logic [31:0] loc, input logic [31:0] ts);
        return {args, tt, loc, ts};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_a(input int s, output logic [31:0] v);
        sel_a = 8'(s);
        #1;
        v = state_a;
    endtask

    task automatic read_b(input int s, output logic [31:0] v);
        sel_b = 8'(s);
        #1;
        v = state_b;
    endtask

    // One non-spawning task through u_a (DRAIN 0): start, DONE, back to IDLE.
    task automatic run_a(input logic [TQ-1:0] t);
        task_in = t;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] va, vb;
        rst = 1'b1; start_a = 0; start_b = 0; tready_a = 1; tready_b = 0;
        task_in = '0; spawn_en = 0; spawn_ttype = 0; stat_clr = 0; sel_a = 0; sel_b = 0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (idle_a !== 1'b1 || ready_a !== 1'b1 || done_a !== 1'b0 ||
            idle_b !== 1'b1 || ready_b !== 1'b1 || done_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: a idle/ready/done=%b%b%b b=%b%b%b, want 110",
                     idle_a, ready_a, done_a, idle_b, ready_b, done_b);
        end
        n_checks++;
        if (tvalid_a !== 1'b0 || tvalid_b !== 1'b0 || tdata_a !== '0 || tdata_b !== '0) begin
            n_fail++;
            $display("FAIL reset_stream: tvalid a=%b b=%b tdata a=%h b=%h, want 0", tvalid_a,
                     tvalid_b, tdata_a, tdata_b);
        end
        n_checks++;
        if ({a_undo_vld, a_awvalid, a_wvalid, a_arvalid, a_bready, a_rready,
             b_undo_vld, b_awvalid, b_wvalid, b_arvalid, b_bready, b_rready} !== 12'd0) begin
            n_fail++;
            $display("FAIL side_ports: some undo/AXI handshake output is not 0");
        end
        for (int s = 0; s <= 9; s++) begin
            read_a(s, va);
            read_b(s, vb);
            n_checks++;
            if (va !== 32'd0 || vb !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_ap_state sel=%0d: a=%h b=%h, want 0", s, va, vb);
            end
        end
    endtask

    task automatic test_single();
        int t_done, t_idle;
        logic [31:0] v;
        spawn_en = 1'b0;
        task_in = mk(64'h1, 4'd2, 32'h5, 32'h100);
        start_a = 1'b1;
        t_done = -1; t_idle = -1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            start_a = 1'b0;
            if (done_a && t_done < 0) t_done = c;
            if (idle_a && t_idle < 0) t_idle = c;
        end
        n_checks++;
        if (t_done != 1 || t_idle != 2) begin
            n_fail++;
            $display("FAIL single_latency: done@%0d idle@%0d, want done@1 idle@2", t_done, t_idle);
        end
        read_a(2, v);
        n_checks++;
        if (v !== 32'd1) begin n_fail++; $display("FAIL single_cnt2: got %0d want 1", v); end
        read_a(8, v);
        n_checks++;
        if (v !== 32'd1) begin n_fail++; $display("FAIL single_total: got %0d want 1", v); end
        read_a(0, v);
        n_checks++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL single_cnt0: got %0d want 0", v); end
    endtask

    // Held ap_start with no drain and no spawn: one retirement every 2 cycles,
    // 20 tasks saturate the 4-bit counters at 15.
    task automatic test_back_to_back();
        int n_done;
        logic bad_phase;
        logic [31:0] v;
        task_in = mk(64'h2, 4'd0, 32'h6, 32'h100);
        start_a = 1'b1;
        n_done = 0; bad_phase = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (done_a === 1'b1) n_done++;
            if (done_a !== 1'(c % 2)) bad_phase = 1'b1;
            if (c == 39) start_a = 1'b0;
        end
        n_checks++;
        if (n_done != 20 || bad_phase) begin
            n_fail++;
            $display("FAIL b2b_throughput: dones=%0d phase_err=%b, want 20 and 0", n_done, bad_phase);
        end
        read_a(0, v);
        n_checks++;
        if (v !== 32'd15) begin n_fail++; $display("FAIL sat_cnt0: got %0d want 15", v); end
        read_a(8, v);
        n_checks++;
        if (v !== 32'd15) begin n_fail++; $display("FAIL sat_total: got %0d want 15", v); end
        read_a(2, v);
        n_checks++;
        if (v !== 32'd1) begin n_fail++; $display("FAIL sat_cnt2: got %0d want 1", v); end
    endtask

    task automatic test_clr_with_done();
        logic [31:0] v;
        task_in = mk(64'h3, 4'd0, 32'h6, 32'h100);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n_checks++;
        if (done_a !== 1'b1) begin n_fail++; $display("FAIL clr_done_pulse: got %b want 1", done_a); end
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        read_a(8, v);
        n_checks++;
        if (v !== 32'd1) begin n_fail++; $display("FAIL clr_total: got %0d want 1", v); end
        read_a(0, v);
        n_checks++;
        if (v !== 32'd1) begin n_fail++; $display("FAIL clr_cnt0: got %0d want 1", v); end
        read_a(2, v);
        n_checks++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL clr_cnt2: got %0d want 0", v); end
    endtask

    // ttype 12 is beyond NUM_TTYPES; ts 0x50 is below the previous 0x100.
    task automatic test_ttype_oob();
        logic [31:0] v;
        run_a(mk(64'h4, 4'd12, 32'h7, 32'h50));
        read_a(8, v);
        n_checks++;
        if (v !== {ORD_EN, 31'd2}) begin n_fail++; $display("FAIL oob_total: got %h want %h", v, {ORD_EN, 31'd2}); end
        read_a(0, v);
        n_checks++;
        if (v !== {ORD_EN, 31'd1}) begin n_fail++; $display("FAIL oob_cnt0: got %h want %h", v, {ORD_EN, 31'd1}); end
        read_a(12, v);
        n_checks++;
        if (v !== {ORD_EN, 31'd0}) begin n_fail++; $display("FAIL oob_sel12: got %h want %h", v, {ORD_EN, 31'd0}); end
    endtask

    // u_b, ttype mismatch: plain drain; a start pulse during DRAIN is ignored.
    task automatic test_drain_nospawn();
        int t_done;
        logic any_valid;
        logic [1:0] dbg_c2;
        logic [31:0] v;
        spawn_en = 1'b1; spawn_ttype = 4'd2;
        task_in = mk(64'h10, 4'd3, 32'h8, 32'h10);
        start_b = 1'b1;
        t_done = -1; any_valid = 1'b0; dbg_c2 = 2'b00;
        for (int c = 1; c <= 8; c++) begin
            tick();
            start_b = (c == 2);
            if (c == 2) dbg_c2 = dbg_b;
            if (done_b && t_done < 0) t_done = c;
            if (tvalid_b) any_valid = 1'b1;
        end
        start_b = 1'b0;
        n_checks++;
        if (t_done != 4 || any_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_latency: done@%0d tvalid_seen=%b, want done@4 and 0", t_done, any_valid);
        end
        n_checks++;
        if (dbg_c2 !== 2'd1) begin n_fail++; $display("FAIL drain_state: got %0d want 1", dbg_c2); end
        read_b(8, v);
        n_checks++;
        if (v !== 32'd1) begin n_fail++; $display("FAIL drain_total: got %0d want 1", v); end
    endtask

    // Shared child monitor loop for u_b: scoreboard pop at each transfer.
    task automatic run_b_spawn(input int cycles, input int ready_at,
                               output int t_valid, output int t_done, output logic bad);
        logic [TQ-1:0] exp;
        t_valid = -1; t_done = -1; bad = 1'b0;
        for (int c = 1; c <= cycles; c++) begin
            tick();
            start_b = 1'b0;
            if (c == ready_at) tready_b = 1'b1;
            if (tvalid_b && t_valid < 0) t_valid = c;
            if (done_b && t_done < 0) t_done = c;
            if (tvalid_b === 1'b1) begin
                if (exp_q.size() == 0) bad = 1'b1;
                else if (tdata_b !== exp_q[0]) bad = 1'b1;
                if (tready_b && exp_q.size() != 0) begin
                    exp = exp_q.pop_front();
                    n_checks++;
                    if (tdata_b !== exp) begin
                        n_fail++;
                        $display("FAIL child_data: got %h want %h", tdata_b, exp);
                    end
                end
            end
        end
        tready_b = 1'b0;
    endtask

    task automatic test_spawn_fast();
        int tv, td;
        logic bad;
        logic [31:0] v;
        task_in = mk(64'hCAFE, 4'd2, 32'h77, 32'h20);
        exp_q.push_back(mk(64'hCAFE, 4'd1, 32'h77, 32'h21));
        tready_b = 1'b1;
        start_b = 1'b1;
        run_b_spawn(8, 0, tv, td, bad);
        n_checks++;
        if (tv != 4 || td != 5 || bad || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL spawn_fast: valid@%0d done@%0d bad=%b left=%0d, want 4 5 0 0", tv, td, bad, exp_q.size());
        end
        read_b(9, v);
        n_checks++;
        if (v !== 32'd1) begin n_fail++; $display("FAIL spawn_fast_cnt: got %0d want 1", v); end
    endtask

    // ts wraps to 0; TREADY low for 5 EMIT cycles (4..8), transfer in cycle 9.
    task automatic test_spawn_wrap();
        int tv, td;
        logic bad;
        logic [31:0] v;
        task_in = mk(64'h1122334455667788, 4'd2, 32'hABCD, 32'hFFFFFFFF);
        exp_q.push_back(mk(64'h1122334455667788, 4'd1, 32'hABCD, 32'h0));
        tready_b = 1'b0;
        start_b = 1'b1;
        run_b_spawn(14, 9, tv, td, bad);
        n_checks++;
        if (tv != 4 || td != 10 || bad || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL spawn_wrap: valid@%0d done@%0d bad=%b left=%0d, want 4 10 0 0", tv, td, bad, exp_q.size());
        end
        read_b(9, v);
        n_checks++;
        if (v !== 32'd2) begin n_fail++; $display("FAIL spawn_cnt: got %0d want 2", v); end
        read_b(8, v);
        n_checks++;
        if (v !== 32'd3) begin n_fail++; $display("FAIL spawn_total: got %0d want 3", v); end
        read_b(2, v);
        n_checks++;
        if (v !== 32'd2) begin n_fail++; $display("FAIL spawn_cnt2: got %0d want 2", v); end
    endtask

    task automatic test_reset_mid_emit();
        logic [31:0] va, vb;
        task_in = mk(64'h99, 4'd2, 32'h1, 32'h30);
        tready_b = 1'b0;
        start_b = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            start_b = 1'b0;
        end
        n_checks++;
        if (tvalid_b !== 1'b1) begin n_fail++; $display("FAIL emit_before_rst: tvalid=%b want 1", tvalid_b); end
        if (ORD_EN) begin
            read_a(8, va);
            n_checks++;
            if (va[31] !== 1'b1) begin n_fail++; $display("FAIL order_err_before_rst: got %b want 1", va[31]); end
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (tvalid_b !== 1'b0 || tdata_b !== '0) begin
            n_fail++;
            $display("FAIL rst_drop: tvalid=%b tdata=%h, want 0", tvalid_b, tdata_b);
        end
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        read_b(8, vb);
        read_a(8, va);
        n_checks++;
        if (vb !== 32'd0 || va !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_counters: b_total=%h a_total=%h (bit31 = order_err), want 0", vb, va);
        end
        read_b(9, vb);
        n_checks++;
        if (vb !== 32'd0) begin n_fail++; $display("FAIL rst_spawn_cnt: got %0d want 0", vb); end
    endtask

    task automatic test_order_check();
        logic [31:0] v;
        run_a(mk(64'h5, 4'd1, 32'h2, 32'd10));
        read_a(8, v);
        n_checks++;
        if (v !== {1'b0, 31'd1}) begin n_fail++; $display("FAIL order_first: got %h want %h", v, {1'b0, 31'd1}); end
        run_a(mk(64'h5, 4'd1, 32'h2, 32'd5));
        read_a(8, v);
        n_checks++;
        if (v !== {ORD_EN, 31'd2}) begin n_fail++; $display("FAIL order_set: got %h want %h", v, {ORD_EN, 31'd2}); end
        run_a(mk(64'h5, 4'd1, 32'h2, 32'd20));
        read_a(8, v);
        n_checks++;
        if (v !== {ORD_EN, 31'd3}) begin n_fail++; $display("FAIL order_sticky: got %h want %h", v, {ORD_EN, 31'd3}); end
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        read_a(8, v);
        n_checks++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL order_clr: got %h want 0", v); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_clr_with_done();
        test_ttype_oob();
        test_drain_nospawn();
        test_spawn_fast();
        test_spawn_wrap();
        test_reset_mid_emit();
        test_order_check();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

endmodule
